// File: rtl/scpad_tile_reader_if.sv
// Bundle of the tile reader's handshake and data channels.
//
//   cmd_* : tile-load command (valid/ready) from the consumer side.
//   req_* : single-row SRAM read requests toward the scratchpad (valid/ready).
//   res_* : tagged read responses from the scratchpad (valid only, never stalled).
//   out_* : in-order row stream toward the consumer (valid/ready).
//   done  : one-cycle pulse when a tile has been fully delivered.
//   err   : sticky flag for responses that hit an unallocated or already-filled slot.
//   dbg_state : current control state of the reader, for observation only.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised, the
// sender keeps valid and its payload unchanged until that transfer happens.
//
// The "slave" modport is the tile reader itself; "master" is its environment.
interface scpad_tile_reader_if #(
  parameter int NUM_COLS        = 32,
  parameter int DATA_W          = 16,
  parameter int ROW_IDX_WIDTH   = 8,
  parameter int NUM_SCPADS      = 2,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int ID_W  = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1;
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int ROW_W = NUM_COLS * DATA_W;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ID_W-1:0]          cmd_scpad_id;
  logic [ROW_IDX_WIDTH-1:0] cmd_base_row;
  logic [ROW_IDX_WIDTH-1:0] cmd_num_rows;

  logic                     req_valid;
  logic                     req_ready;
  logic [ID_W-1:0]          req_scpad_id;
  logic [ROW_IDX_WIDTH-1:0] req_row;
  logic [TAG_W-1:0]         req_tag;

  logic                     res_valid;
  logic [TAG_W-1:0]         res_tag;
  logic [ROW_W-1:0]         res_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_data;
  logic                     out_last;

  logic                     done;
  logic                     err;
  logic [1:0]               dbg_state;

  modport slave (
    input  cmd_valid, cmd_scpad_id, cmd_base_row, cmd_num_rows,
    output cmd_ready,
    output req_valid, req_scpad_id, req_row, req_tag,
    input  req_ready,
    input  res_valid, res_tag, res_data,
    output out_valid, out_data, out_last,
    input  out_ready,
    output done, err, dbg_state
  );

  modport master (
    output cmd_valid, cmd_scpad_id, cmd_base_row, cmd_num_rows,
    input  cmd_ready,
    input  req_valid, req_scpad_id, req_row, req_tag,
    output req_ready,
    output res_valid, res_tag, res_data,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  done, err, dbg_state
  );
endinterface

// File: rtl/scpad_tile_reader.sv
// Scratchpad tile reader.
//
// Turns one tile-load command (scratchpad id, base row, row count) into a
// stream of single-row read requests, each tagged with a reorder-buffer slot.
// Responses may come back out of order across tags; they are parked in the
// reorder buffer and handed to the consumer strictly in request order.
//
// Ports:
//   clk   : clock, all state updates on the rising edge.
//   n_rst : asynchronous active-low reset.
//   bus   : scpad_tile_reader_if.slave
//             cmd_*  tile command in (valid/ready)
//             req_*  row read requests out (valid/ready), tag = ROB slot
//             res_*  tagged read responses in (always accepted)
//             out_*  ordered row stream out (valid/ready), out_last on final row
//             done   one-cycle pulse the cycle after the final row is taken
//             err    sticky: response for an unallocated or already-filled slot
//             dbg_state  control state (0 idle, 1 issue, 2 drain)
module scpad_tile_reader #(
  parameter int NUM_COLS        = 32,
  parameter int DATA_W          = 16,
  parameter int ROW_IDX_WIDTH   = 8,
  parameter int NUM_SCPADS      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               n_rst,
  scpad_tile_reader_if.slave bus
);
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int ID_W  = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1;
  localparam int ROW_W = NUM_COLS * DATA_W;
  // Counters carry one extra bit so a full 2^ROW_IDX_WIDTH-1 row tile counts
  // to completion without wrapping.
  localparam int CNT_W = ROW_IDX_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_INFLIGHT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [TAG_W-1:0] TAG_ONE      = TAG_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   state;
  logic                     cmd_ready_q;
  logic                     done_q;
  logic                     err_q;
  logic [ID_W-1:0]          scpad_q;
  logic [ROW_IDX_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         issued_q;
  logic [CNT_W-1:0]         popped_q;
  logic [TAG_W-1:0]         issue_ptr;
  logic [TAG_W-1:0]         pop_ptr;

  // Per-slot bookkeeping: allocated = request sent and row not yet popped,
  // filled = response data is sitting in the slot.
  logic [MAX_OUTSTANDING-1:0] alloc_q;
  logic [MAX_OUTSTANDING-1:0] filled_q;
  logic [MAX_OUTSTANDING-1:0] alloc_d;
  logic [MAX_OUTSTANDING-1:0] filled_d;
  logic [ROW_W-1:0]           rob_data [MAX_OUTSTANDING];

  logic [CNT_W-1:0] inflight;
  logic             req_valid_c;
  logic             req_fire;
  logic             out_valid_c;
  logic             pop_fire;
  logic             cmd_fire;
  logic             res_ok;
  logic             res_bad;
  logic             last_issue;
  logic             last_pop;

  // Inflight uses registered counts only, so a slot freed by a pop becomes
  // issuable one cycle later rather than in the same cycle.
  assign inflight    = issued_q - popped_q;
  assign req_valid_c = (state == S_ISSUE) && (issued_q < count_q) &&
                       (inflight < MAX_INFLIGHT);
  assign req_fire    = req_valid_c && bus.req_ready;
  assign last_issue  = (issued_q + CNT_ONE) == count_q;

  // The head slot is only visible once its fill bit is registered, so a
  // response and a pop can never target the same slot in one cycle.
  assign out_valid_c = filled_q[pop_ptr];
  assign pop_fire    = out_valid_c && bus.out_ready;
  assign last_pop    = (popped_q + CNT_ONE) == count_q;

  assign cmd_fire    = cmd_ready_q && bus.cmd_valid;

  assign res_ok      = bus.res_valid && alloc_q[bus.res_tag] && !filled_q[bus.res_tag];
  assign res_bad     = bus.res_valid && !res_ok;

  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    if (req_fire) begin
      alloc_d[issue_ptr] = 1'b1;
    end
    if (res_ok) begin
      filled_d[bus.res_tag] = 1'b1;
    end
    if (pop_fire) begin
      alloc_d[pop_ptr]  = 1'b0;
      filled_d[pop_ptr] = 1'b0;
    end
  end

  // Control FSM plus the counters and slot flags it owns.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      scpad_q     <= '0;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      issue_ptr   <= '0;
      pop_ptr     <= '0;
      alloc_q     <= '0;
      filled_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      alloc_q  <= alloc_d;
      filled_q <= filled_d;

      if (res_bad) begin
        err_q <= 1'b1;
      end

      if (req_fire) begin
        issued_q  <= issued_q + CNT_ONE;
        issue_ptr <= issue_ptr + TAG_ONE;
      end

      if (pop_fire) begin
        popped_q <= popped_q + CNT_ONE;
        pop_ptr  <= pop_ptr + TAG_ONE;
      end

      unique case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            scpad_q  <= bus.cmd_scpad_id;
            base_q   <= bus.cmd_base_row;
            count_q  <= {1'b0, bus.cmd_num_rows};
            issued_q <= '0;
            popped_q <= '0;
            if (bus.cmd_num_rows == '0) begin
              // Empty tile: nothing to fetch, report completion right away
              // and keep accepting commands.
              done_q <= 1'b1;
            end else begin
              state       <= S_ISSUE;
              cmd_ready_q <= 1'b0;
            end
          end
        end

        S_ISSUE: begin
          if (req_fire && last_issue) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // cmd_ready rises together with done so a follow-on command can be
          // accepted in the done cycle.
          if (pop_fire && last_pop) begin
            state       <= S_IDLE;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Row storage carries no reset; the fill bits alone say what is valid.
  always_ff @(posedge clk) begin
    if (res_ok) begin
      rob_data[bus.res_tag] <= bus.res_data;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.req_valid    = req_valid_c;
  assign bus.req_scpad_id = scpad_q;
  assign bus.req_row      = base_q + issued_q[ROW_IDX_WIDTH-1:0];
  assign bus.req_tag      = issue_ptr;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = rob_data[pop_ptr];
  assign bus.out_last     = out_valid_c && (popped_q == (count_q - CNT_ONE));
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_scpad_tile_reader.sv
// Bench for scpad_tile_reader: directed scenarios plus randomized tiles,
// checked every cycle against a queue-based model of request order and
// response arrival.
module tb_scpad_tile_reader;
  localparam int NUM_COLS = 32;
  localparam int DATA_W   = 16;
  localparam int ROWW     = 8;
  localparam int NSP      = 2;
  localparam int MAXO     = 4;
  localparam int W        = NUM_COLS * DATA_W;

  logic clk;
  logic n_rst;

  scpad_tile_reader_if #(.NUM_COLS(NUM_COLS), .DATA_W(DATA_W), .ROW_IDX_WIDTH(ROWW),
                         .NUM_SCPADS(NSP), .MAX_OUTSTANDING(MAXO)) ifc ();

  scpad_tile_reader #(.NUM_COLS(NUM_COLS), .DATA_W(DATA_W), .ROW_IDX_WIDTH(ROWW),
                      .NUM_SCPADS(NSP), .MAX_OUTSTANDING(MAXO)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (ifc.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and checkers ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- model state ----------------
  // Scoreboard: rows in request order with their tag and whether the
  // response has already landed.
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_tag_q[$];
  bit           exp_arr_q[$];
  // Responses the bench still owes the DUT.
  logic [1:0]   pend_tag[$];
  logic [W-1:0] pend_data[$];
  int           pend_due[$];

  bit   m_busy;
  int   m_base, m_count, m_issued, m_popped, m_id, m_tag;
  bit   cmd_ready_exp, done_exp, err_exp;

  // Responder policy.
  int   dly_min = 1, dly_max = 1;
  bit   rsp_random = 0;
  int   rsp_order[$];
  bit   inject_pending = 0;
  logic [1:0] inject_tag = '0;

  // Logs for the hand-computed expectations.
  int acc_cyc_log[$], req_row_log[$], req_tag_log[$], req_cyc_log[$];
  int pop_tag_log[$], pop_cyc_log[$], pop_last_log[$], done_cyc_log[$];

  task automatic clear_logs();
    acc_cyc_log.delete(); req_row_log.delete(); req_tag_log.delete(); req_cyc_log.delete();
    pop_tag_log.delete(); pop_cyc_log.delete(); pop_last_log.delete(); done_cyc_log.delete();
  endtask

  // ---------------- model + compare + responder (one process) ----------------
  initial begin
    bit rv_exp, ov_exp, last_exp;
    int sel;
    int elig[$];
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        exp_q.delete(); exp_tag_q.delete(); exp_arr_q.delete();
        pend_tag.delete(); pend_data.delete(); pend_due.delete();
        m_busy = 0; m_issued = 0; m_popped = 0; m_count = 0; m_tag = 0;
        cmd_ready_exp = 0; done_exp = 0; err_exp = 0;
        ifc.res_valid = 1'b0;
        continue;
      end

      // 1) compare outputs with what the model says must be visible now
      rv_exp = m_busy && (m_issued < m_count) && ((m_issued - m_popped) < MAXO);
      ov_exp = (exp_q.size() > 0) && exp_arr_q[0];
      last_exp = (m_popped + 1 == m_count);
      chk("cmd_ready", 64'(ifc.cmd_ready), 64'(cmd_ready_exp));
      chk("req_valid", 64'(ifc.req_valid), 64'(rv_exp));
      if (rv_exp) begin
        chk("req_row", 64'(ifc.req_row), 64'((m_base + m_issued) % 256));
        chk("req_tag", 64'(ifc.req_tag), 64'(m_tag));
        chk("req_scpad_id", 64'(ifc.req_scpad_id), 64'(m_id));
      end
      chk("out_valid", 64'(ifc.out_valid), 64'(ov_exp));
      if (ov_exp) begin
        chk_data("out_data", ifc.out_data, exp_q[0]);
        chk("out_last", 64'(ifc.out_last), 64'(last_exp));
      end
      chk("done", 64'(ifc.done), 64'(done_exp));
      chk("err", 64'(ifc.err), 64'(err_exp));
      if (ifc.done) done_cyc_log.push_back(cyc);

      // 2) choose the response to present at the coming edge
      ifc.res_valid = 1'b0;
      if (inject_pending) begin
        ifc.res_valid = 1'b1;
        ifc.res_tag   = inject_tag;
        ifc.res_data  = rand_row();
        inject_pending = 0;
      end else if (pend_tag.size() > 0) begin
        sel = -1;
        if (rsp_order.size() > 0) begin
          for (int i = 0; i < pend_tag.size(); i++)
            if (int'(pend_tag[i]) == rsp_order[0] && pend_due[i] <= cyc) sel = i;
        end else if (rsp_random) begin
          elig.delete();
          for (int i = 0; i < pend_tag.size(); i++)
            if (pend_due[i] <= cyc) elig.push_back(i);
          if (elig.size() > 0) sel = elig[$urandom_range(0, elig.size() - 1)];
        end else if (pend_due[0] <= cyc) begin
          sel = 0;
        end
        if (sel >= 0) begin
          ifc.res_valid = 1'b1;
          ifc.res_tag   = pend_tag[sel];
          ifc.res_data  = pend_data[sel];
          pend_tag.delete(sel); pend_data.delete(sel); pend_due.delete(sel);
          if (rsp_order.size() > 0) void'(rsp_order.pop_front());
        end
      end

      // 3) advance the model across the coming edge
      done_exp = 0;
      if (cmd_ready_exp && ifc.cmd_valid) begin
        acc_cyc_log.push_back(cyc);
        m_base = int'(ifc.cmd_base_row); m_count = int'(ifc.cmd_num_rows);
        m_id = int'(ifc.cmd_scpad_id); m_issued = 0; m_popped = 0;
        if (m_count == 0) done_exp = 1;
        else m_busy = 1;
      end
      if (ifc.res_valid) begin
        sel = -1;
        for (int i = 0; i < exp_tag_q.size(); i++)
          if (exp_tag_q[i] == ifc.res_tag && !exp_arr_q[i]) sel = i;
        if (sel >= 0) begin
          exp_q[sel] = ifc.res_data;
          exp_arr_q[sel] = 1;
        end else begin
          err_exp = 1;
        end
      end
      if (ov_exp && ifc.out_ready) begin
        pop_tag_log.push_back(int'(exp_tag_q[0]));
        pop_cyc_log.push_back(cyc);
        pop_last_log.push_back(int'(ifc.out_last));
        void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); void'(exp_arr_q.pop_front());
        m_popped++;
        if (m_popped == m_count) begin
          m_busy = 0;
          done_exp = 1;
        end
      end
      if (rv_exp && ifc.req_ready) begin
        logic [W-1:0] d;
        d = rand_row();
        req_row_log.push_back((m_base + m_issued) % 256);
        req_tag_log.push_back(m_tag);
        req_cyc_log.push_back(cyc);
        exp_q.push_back('0);
        exp_tag_q.push_back(2'(m_tag));
        exp_arr_q.push_back(0);
        pend_tag.push_back(2'(m_tag));
        pend_data.push_back(d);
        pend_due.push_back(cyc + $urandom_range(dly_min, dly_max));
        m_tag = (m_tag + 1) % MAXO;
        m_issued++;
      end
      cmd_ready_exp = !m_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic send_cmd(input int id, input int base, input int count);
    int n = 0;
    @(posedge clk); #1;
    ifc.cmd_valid    = 1'b1;
    ifc.cmd_scpad_id = 1'(id);
    ifc.cmd_base_row = 8'(base);
    ifc.cmd_num_rows = 8'(count);
    forever begin
      @(negedge clk);
      if (ifc.cmd_ready) break;
      n++;
      if (n > 2000) begin
        chk("cmd_accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
  endtask

  // mode 0: hold readies, 1: random readies, 2: toggle req_ready each cycle
  task automatic wait_idle(input int budget, input int mode);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (mode == 1) begin
        ifc.req_ready = ($urandom_range(0, 3) != 0);
        ifc.out_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        ifc.req_ready = !ifc.req_ready;
      end
      @(negedge clk); #1;
      if (!m_busy && exp_q.size() == 0) break;
      n++;
      if (n >= budget) begin
        chk("wait_idle_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    ifc.req_ready = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    n_rst = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_scpad_id = '0; ifc.cmd_base_row = '0; ifc.cmd_num_rows = '0;
    ifc.req_ready = 1'b1; ifc.out_ready = 1'b1;
    ifc.res_valid = 1'b0; ifc.res_tag = '0; ifc.res_data = '0;
    #12;
    chk("rst_cmd_ready", 64'(ifc.cmd_ready), 64'(0));
    chk("rst_req_valid", 64'(ifc.req_valid), 64'(0));
    chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("rst_done", 64'(ifc.done), 64'(0));
    chk("rst_err", 64'(ifc.err), 64'(0));

    // Basic in-order read
    do_reset();
    dly_min = 2; dly_max = 2; rsp_random = 0;
    clear_logs();
    send_cmd(1, 10, 3);
    wait_idle(200, 0);
    chk("basic_nreq", 64'(req_row_log.size()), 64'(3));
    if (req_row_log.size() == 3) begin
      chk("basic_row0", 64'(req_row_log[0]), 64'(10));
      chk("basic_row1", 64'(req_row_log[1]), 64'(11));
      chk("basic_row2", 64'(req_row_log[2]), 64'(12));
      chk("basic_tag2", 64'(req_tag_log[2]), 64'(2));
      chk("basic_first_req_latency", 64'(req_cyc_log[0] - acc_cyc_log[0]), 64'(1));
    end
    chk("basic_npop", 64'(pop_cyc_log.size()), 64'(3));
    chk("basic_ndone", 64'(done_cyc_log.size()), 64'(1));
    if (pop_cyc_log.size() == 3 && done_cyc_log.size() == 1) begin
      chk("basic_last_flag", 64'(pop_last_log[2]), 64'(1));
      chk("basic_done_after_pop", 64'(done_cyc_log[0] - pop_cyc_log[2]), 64'(1));
    end

    // Out-of-order responses
    do_reset();
    dly_min = 1; dly_max = 1;
    rsp_order = '{3, 1, 0, 2};
    clear_logs();
    send_cmd(0, 40, 4);
    wait_idle(200, 0);
    chk("ooo_npop", 64'(pop_tag_log.size()), 64'(4));
    if (pop_tag_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("ooo_pop_tag", 64'(pop_tag_log[i]), 64'(i));
    rsp_order.delete();

    // Full ROB and backpressure
    do_reset();
    dly_min = 1; dly_max = 1;
    clear_logs();
    ifc.out_ready = 1'b0;
    send_cmd(1, 100, 8);
    repeat (12) @(negedge clk);
    #1;
    chk("full_nreq", 64'(req_row_log.size()), 64'(4));
    chk("full_req_valid_low", 64'(ifc.req_valid), 64'(0));
    chk("full_out_valid", 64'(ifc.out_valid), 64'(1));
    @(posedge clk); #1 ifc.out_ready = 1'b1;
    wait_idle(300, 0);
    chk("full_npop", 64'(pop_tag_log.size()), 64'(8));
    if (pop_tag_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("full_pop_tag", 64'(pop_tag_log[i]), 64'(i % 4));

    // Row wrap with stalling requests
    do_reset();
    dly_min = 1; dly_max = 3; rsp_random = 1;
    clear_logs();
    ifc.req_ready = 1'b0;
    send_cmd(1, 254, 4);
    wait_idle(300, 2);
    chk("wrap_nreq", 64'(req_row_log.size()), 64'(4));
    if (req_row_log.size() == 4) begin
      chk("wrap_row0", 64'(req_row_log[0]), 64'(254));
      chk("wrap_row1", 64'(req_row_log[1]), 64'(255));
      chk("wrap_row2", 64'(req_row_log[2]), 64'(0));
      chk("wrap_row3", 64'(req_row_log[3]), 64'(1));
    end
    rsp_random = 0;

    // Zero count followed by a command accepted in the done cycle
    do_reset();
    dly_min = 1; dly_max = 2;
    clear_logs();
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1; ifc.cmd_scpad_id = 1'b0; ifc.cmd_base_row = 8'd7; ifc.cmd_num_rows = 8'd0;
    @(negedge clk);
    chk("zero_ready", 64'(ifc.cmd_ready), 64'(1));
    @(posedge clk); #1;
    ifc.cmd_scpad_id = 1'b1; ifc.cmd_base_row = 8'd20; ifc.cmd_num_rows = 8'd1;
    @(negedge clk);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    wait_idle(100, 0);
    chk("zero_nacc", 64'(acc_cyc_log.size()), 64'(2));
    chk("zero_ndone", 64'(done_cyc_log.size()), 64'(2));
    chk("zero_nreq", 64'(req_row_log.size()), 64'(1));
    if (acc_cyc_log.size() == 2 && done_cyc_log.size() == 2 && req_row_log.size() == 1) begin
      chk("zero_done_cycle1", 64'(done_cyc_log[0] - acc_cyc_log[0]), 64'(1));
      chk("b2b_accept_in_done", 64'(acc_cyc_log[1]), 64'(done_cyc_log[0]));
      chk("b2b_row", 64'(req_row_log[0]), 64'(20));
    end

    // Stray response while idle, then reset mid-issue
    do_reset();
    clear_logs();
    inject_tag = 2'd2;
    inject_pending = 1;
    repeat (4) @(negedge clk);
    #1;
    chk("stray_err", 64'(ifc.err), 64'(1));
    chk("stray_no_out", 64'(ifc.out_valid), 64'(0));
    dly_min = 3; dly_max = 3;
    send_cmd(0, 0, 6);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_cmd_ready", 64'(ifc.cmd_ready), 64'(0));
    chk("midrst_req_valid", 64'(ifc.req_valid), 64'(0));
    chk("midrst_out_valid", 64'(ifc.out_valid), 64'(0));
    chk("midrst_out_last", 64'(ifc.out_last), 64'(0));
    chk("midrst_done", 64'(ifc.done), 64'(0));
    chk("midrst_err", 64'(ifc.err), 64'(0));
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Randomized tiles
    dly_min = 1; dly_max = 6; rsp_random = 1;
    for (int t = 0; t < 10; t++) begin
      int cnt;
      cnt = (t == 5) ? 255 : $urandom_range(0, 12);
      send_cmd($urandom_range(0, 1), $urandom_range(0, 255), cnt);
      wait_idle(4000, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/scpad_tile_reader.md
Name: scpad_tile_reader

Overview:
- Initiator-side client of the scratchpad read port: turns one tile-load command (scratchpad id, base row, row count) into a stream of single-row SRAM read requests, each with a tag.
- Collects tagged read responses, which may return out of order across tags, in a small reorder buffer.
- Emits row data strictly in request order on a valid/ready stream toward the consumer (systolic array or vector core load path).
- Sits between the consumer and the scratchpad frontend read request/response channels.

Parameters:
NUM_COLS, 32, banks per scratchpad row (row = NUM_COLS words)
DATA_W, 16, bits per bank word
ROW_IDX_WIDTH, 8, row index width
NUM_SCPADS, 2, scratchpads addressable
MAX_OUTSTANDING, 4, reorder-buffer depth and tag space (power of 2); TAG_W = log2(MAX_OUTSTANDING)

Ports:
clk  in  1  clock, all state on rising edge
n_rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  tile command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_scpad_id  in  clog2(NUM_SCPADS)  target scratchpad
cmd_base_row  in  ROW_IDX_WIDTH  first row
cmd_num_rows  in  ROW_IDX_WIDTH  rows to read (0 legal)
req_valid  out  1  SRAM read request valid
req_ready  in  1  request taken when valid&ready
req_scpad_id  out  clog2(NUM_SCPADS)  latched scratchpad id
req_row  out  ROW_IDX_WIDTH  row address
req_tag  out  TAG_W  tag = ROB slot
res_valid  in  1  read response valid (no backpressure, always consumed)
res_tag  in  TAG_W  response tag
res_data  in  NUM_COLS*DATA_W  row data
out_valid  out  1  ordered row valid
out_ready  in  1  consumer accepts
out_data  out  NUM_COLS*DATA_W  row data
out_last  out  1  final row of tile
done  out  1  one-cycle pulse, tile complete
err  out  1  sticky protocol error

Behaviour:
- Reset (async, n_rst=0): state IDLE; issue, pop and tag pointers = 0; all ROB valid bits = 0; err = 0.
- Reset outputs: cmd_ready=0 while n_rst is low, 1 in IDLE afterwards; req_valid=0, out_valid=0, out_last=0, done=0.
- Reset mid-operation discards all state; the bench must not drive responses for pre-reset tags.
- FSM IDLE:
  - cmd_ready=1.
  - On accept: latch id, base and count; clear the issued and popped counters.
  - If count==0: go straight to a done pulse on the next cycle and stay IDLE.
  - Otherwise go to ISSUE.
- FSM ISSUE:
  - cmd_ready=0.
  - req_valid=1 when issued<count and inflight<MAX_OUTSTANDING, where inflight = issued - popped.
  - req_row = (base + issued) mod 2^ROW_IDX_WIDTH; row index wraps, no error.
  - req_tag = issue pointer.
  - On handshake: mark the slot allocated, increment the pointer (mod MAX_OUTSTANDING) and increment issued.
  - req_valid, req_row and req_tag hold stable while req_ready=0.
  - After the last handshake go to DRAIN.
- FSM DRAIN:
  - No requests issued.
  - When the final row pops (popped reaches count), go to IDLE and assert done for one cycle on the next cycle.
  - The next command can be accepted in the same cycle done is high.
- Latency:
  - Command accept at cycle 0 -> first req_valid at cycle 1.
  - res_valid at cycle t -> data written to ROB -> earliest out_valid at t+1.
- ROB:
  - res_valid writes res_data to slot res_tag and sets its filled bit.
  - out_valid = filled[pop pointer]; out_data = that slot.
  - out_last = 1 when popped == count-1.
  - On out handshake: clear allocated and filled, increment pop pointer and popped.
- Slot reuse: a freed slot becomes issuable the cycle after its pop, so inflight uses registered counts.
- Simultaneous events:
  - Issue, response write and pop in the same cycle on distinct slots are all legal.
  - A response for the head slot plus a pop in the same cycle is impossible; the head is not filled until registered.
- Errors:
  - res_valid for an unallocated tag, or for an already-filled slot, is dropped and sets err=1.
  - err is sticky until reset.
- Width rule: issued, popped and count are ROW_IDX_WIDTH+1 bits internally, so count=255 completes without overflow.

Test Plan:
- Basic in-order read: base=10, count=3, req_ready=1, responses returned 2 cycles after each request in order -> req_row 10,11,12 with tags 0,1,2; out rows in order; out_last on the 3rd; done one cycle after the 3rd pop.
- Out-of-order responses: count=4, responses returned in tag order 3,1,0,2 -> output order tags 0,1,2,3; out_valid stays low until tag 0 has arrived.
- Full ROB and backpressure: count=8, out_ready=0, responses immediate -> exactly 4 requests issued, then req_valid=0. Raise out_ready -> tags 0..3 reused, 8 rows delivered in order.
- Row wrap and request stall: base=254, count=4, req_ready toggling every cycle -> req_row sequence 254,255,0,1 with each value held stable while stalled.
- Zero count and back-to-back commands: count=0 -> no requests, done pulse at cycle 1. A second command (count=1) accepted in the done cycle completes normally.
- Error and reset: res_valid with tag 2 while IDLE -> err=1 and no output. Assert n_rst mid-ISSUE -> all outputs return to reset values immediately and err clears.
